sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
Round-robin arbiter that shares the single SDRAMBus port among the core's requesters: LoadCore, MixCore, PitchCore, RecordCore and PlayCore. It replaces the OR-combining of request signals, so requesters no longer need to zero their unused outputs. Each transaction's op, address and write data are latched at grant. Exactly one transaction is in flight at a time. A watchdog aborts transactions that SDRAMBus never completes.

Parameters:
NUM_REQ, 5, number of requesters (index 0=load, 1=mix, 2=pitch, 3=record, 4=play)
ADDR_W, 23, SDRAM word address width
DATA_W, 32, SDRAM data width
TIMEOUT_CYCLES, 1024, cycles in BUSY before abort; 0 disables the watchdog
CNT_W, 16, watchdog counter width; must satisfy TIMEOUT_CYCLES < 2^CNT_W

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
req_read  in  NUM_REQ  per-requester read request, held until its req_finished
req_write  in  NUM_REQ  per-requester write request, held until its req_finished
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
req_writedata  in  NUM_REQ*DATA_W  packed write data; same slicing scheme
req_finished  out  NUM_REQ  one-cycle completion pulse to the granted requester
req_readdata  out  DATA_W  shared read data, valid only in a req_finished cycle
grant  out  NUM_REQ  one-hot owner of the current transaction; all zero when not BUSY
sdram_read  out  1  to SDRAMBus
sdram_write  out  1  to SDRAMBus
sdram_addr  out  ADDR_W  to SDRAMBus
sdram_writedata  out  DATA_W  to SDRAMBus
sdram_readdata  in  DATA_W  from SDRAMBus
sdram_finished  in  1  from SDRAMBus, one-cycle pulse per completed access
timeout_err  out  1  sticky watchdog error flag
timeout_id  out  $clog2(NUM_REQ)  index of the requester whose transaction timed out

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - rr_last = NUM_REQ-1, so requester 0 has top priority after reset.
  - Watchdog count is 0.
- Reset mid-transaction drops the access with no req_finished pulse. Requesters are reset by the same i_rst.
- A requester is "pending" when req_read[i] | req_write[i].
- States are IDLE, BUSY and RELEASE.
- IDLE:
  - If any requester is pending, choose winner g as the first pending index searching rr_last+1, rr_last+2, … modulo NUM_REQ.
  - On that same edge: latch op, addr and writedata of g; set grant=onehot(g); set rr_last=g; go to BUSY.
  - No pending requester: remain in IDLE.
- Op encoding at latch: write if req_write[g]=1, even if req_read[g] is also 1; otherwise read.
- BUSY:
  - sdram_read / sdram_write = latched op (exactly one is high).
  - sdram_addr and sdram_writedata come from latches. Later changes on req_* inputs are ignored.
  - sdram_writedata is driven 0 for reads.
  - The watchdog counter increments every cycle.
- BUSY completion:
  - If sdram_finished=1, combinationally assert req_finished[g]=1 and req_readdata=sdram_readdata in the same cycle.
  - Then go to RELEASE and clear the counter.
- BUSY timeout:
  - If TIMEOUT_CYCLES≠0, the counter reaches TIMEOUT_CYCLES-1, and sdram_finished=0: set timeout_err=1 and timeout_id=g.
  - On the same cycle pulse req_finished[g]=1 with req_readdata=0 (abort), then go to RELEASE.
  - If sdram_finished and the timeout condition coincide, this is a normal completion; no error is raised.
- RELEASE (exactly 1 cycle):
  - sdram_read=sdram_write=0 and grant=0.
  - The requester drops its request during this cycle.
  - Next state is IDLE, which can grant again on the following edge.
- Latency:
  - Request present in IDLE at edge t → sdram_read/write high from t+1.
  - Minimum spacing between two grants is 3 cycles (BUSY ≥1, RELEASE 1, IDLE 1).
- sdram_finished while in IDLE or RELEASE is ignored: no req_finished pulse, no state change.
- req_readdata = sdram_readdata when (BUSY & sdram_finished), else 0.
- req_finished is never asserted for a non-granted index.
- Round-robin fairness: a requester that stays continuously pending is served within NUM_REQ grants.
- timeout_err and timeout_id clear only on i_rst. A later timeout overwrites timeout_id.

Test Plan:
- Single read: req_read[2]=1, addr 0x00_1234; SDRAMBus model returns 0xDEADBEEF after 4 cycles → sdram_read high from cycle 1 with addr 0x001234; grant=5'b00100; req_finished[2] pulses exactly once with req_readdata=0xDEADBEEF; then RELEASE, then IDLE.
- Simultaneous requests: req 0, 1, 3 all asserted after reset, each held until finished → grant order 0, 1, 3; no overlap on sdram_read/write; each req_finished pulses once.
- Fairness: req 1 re-requests continuously while req 4 is pending → grants alternate 1, 4, 1, 4; req 4 is never starved.
- Op precedence and latching: req_write[0]=req_read[0]=1, writedata 0xCAFEF00D; requester changes addr/data mid-BUSY → write is issued; sdram_addr and sdram_writedata hold the grant-time values.
- Watchdog: TIMEOUT_CYCLES=8 and model never asserts sdram_finished for req 3 → req_finished[3] pulses in the 8th BUSY cycle with readdata 0; timeout_err=1 and timeout_id=3, both still set after later successful transactions. Also drive sdram_finished during IDLE → no req_finished pulse.
- Reset mid-transaction: assert i_rst during BUSY of req 2 → next cycle all outputs 0 and state IDLE; first grant after reset goes to req 0 when reqs 0 and 2 are pending.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Bundle between the arbiter, its requesters and SDRAMBus.
// The master side drives requests and SDRAM responses; the slave side is the arbiter.
interface sdram_arbiter_if #(
   parameter int NUM_REQ = 5,
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 32
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req_read;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_writedata;
   logic [NUM_REQ-1:0]        req_finished;
   logic [DATA_W-1:0]         req_readdata;
   logic [NUM_REQ-1:0]        grant;
   logic                      sdram_read;
   logic                      sdram_write;
   logic [ADDR_W-1:0]         sdram_addr;
   logic [DATA_W-1:0]         sdram_writedata;
   logic [DATA_W-1:0]         sdram_readdata;
   logic                      sdram_finished;
   logic                      timeout_err;
   logic [ID_W-1:0]           timeout_id;

   modport master (
      output req_read, req_write, req_addr, req_writedata, sdram_readdata, sdram_finished,
      input  req_finished, req_readdata, grant, sdram_read, sdram_write, sdram_addr,
             sdram_writedata, timeout_err, timeout_id
   );

   modport slave (
      input  req_read, req_write, req_addr, req_writedata, sdram_readdata, sdram_finished,
      output req_finished, req_readdata, grant, sdram_read, sdram_write, sdram_addr,
             sdram_writedata, timeout_err, timeout_id
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAMBus port between NUM_REQ requesters,
// one transaction in flight, with a watchdog that aborts stuck accesses.
module sdram_arbiter #(
   parameter int NUM_REQ        = 5,
   parameter int ADDR_W         = 23,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   sdram_arbiter_if.slave  bus
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

   state_e             state_q, state_d;
   logic [ID_W-1:0]    rr_last_q, rr_last_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               op_wr_q, op_wr_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               terr_q, terr_d;
   logic [ID_W-1:0]    tid_q, tid_d;

   logic [NUM_REQ-1:0] pend;
   logic [ID_W-1:0]    win;
   logic               win_wr;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_data;
   logic               busy, done, to_hit;
   int                 idx;

   assign pend   = bus.req_read | bus.req_write;
   assign busy   = (state_q == BUSY);
   assign done   = busy && bus.sdram_finished;
   // A completion landing on the last watchdog cycle wins over the abort.
   assign to_hit = busy && (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST) && !bus.sdram_finished;

   // Descending scan so the nearest pending index after rr_last is the one kept.
   always_comb begin
      win      = rr_last_q;
      idx      = 0;
      win_wr   = 1'b0;
      win_addr = '0;
      win_data = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(rr_last_q) + k) % NUM_REQ;
         if (|(pend & (NUM_REQ'(1) << idx))) win = ID_W'(idx);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == ID_W'(i)) begin
            win_wr   = bus.req_write[i];
            win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            win_data = bus.req_writedata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      grant_d   = grant_q;
      op_wr_d   = op_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      terr_d    = terr_q;
      tid_d     = tid_q;
      case (state_q)
         IDLE: begin
            if (|pend) begin
               state_d   = BUSY;
               rr_last_d = win;
               grant_d   = NUM_REQ'(1) << win;
               op_wr_d   = win_wr;
               addr_d    = win_addr;
               wdata_d   = win_data;
               cnt_d     = '0;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (done || to_hit) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
            if (to_hit) begin
               terr_d = 1'b1;
               tid_d  = rr_last_q;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         rr_last_q <= LAST_ID;
         grant_q   <= '0;
         op_wr_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         terr_q    <= 1'b0;
         tid_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         grant_q   <= grant_d;
         op_wr_q   <= op_wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         terr_q    <= terr_d;
         tid_q     <= tid_d;
      end
   end

   assign bus.grant           = busy ? grant_q : '0;
   assign bus.sdram_read      = busy & ~op_wr_q;
   assign bus.sdram_write     = busy & op_wr_q;
   assign bus.sdram_addr      = busy ? addr_q : '0;
   assign bus.sdram_writedata = (busy && op_wr_q) ? wdata_q : '0;
   assign bus.req_finished    = (done || to_hit) ? grant_q : '0;
   assign bus.req_readdata    = done ? bus.sdram_readdata : '0;
   assign bus.timeout_err     = terr_q;
   assign bus.timeout_id      = tid_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grant order, latching and watchdog.
module tb_sdram_arbiter;
   localparam int NR = 5;
   localparam int AW = 23;
   localparam int DW = 32;
   localparam int IW = 3;
   localparam int TO = 8;
   localparam int P_IDLE = 0;
   localparam int P_BUSY = 1;
   localparam int P_REL  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] rd, wr;
   logic [AW-1:0] a [NR];
   logic [DW-1:0] d [NR];
   logic          fin;
   logic [DW-1:0] rdat;

   int checks   = 0;
   int failures = 0;
   int m_rr;
   bit m_terr;
   int m_tid;
   int gq[$];

   sdram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

   sdram_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(16)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.req_read       = rd;
   assign bus.req_write      = wr;
   assign bus.sdram_finished = fin;
   assign bus.sdram_readdata = rdat;

   always_comb begin
      bus.req_addr      = '0;
      bus.req_writedata = '0;
      for (int i = 0; i < NR; i++) begin
         bus.req_addr[i*AW +: AW]      = a[i];
         bus.req_writedata[i*DW +: DW] = d[i];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; rd = '0; wr = '0; fin = 1'b0; rdat = '0;
      for (int i = 0; i < NR; i++) begin a[i] = '0; d[i] = '0; end
      repeat (2) tick();
      rst = 1'b0;
      m_rr = NR - 1; m_terr = 1'b0; m_tid = 0;
      gq.delete();
   endtask

   // Random traffic: requesters hold until their finish pulse, drop during the
   // following cycle and re-request afterwards while they have work left.
   task automatic test_traffic(input logic [NR-1:0] mask, input int ntx, input int lat_mode,
                               input bit scramble, input bit idle_fin);
      int rem [NR];
      bit drop [NR];
      int phase, prev_phase, g, bcnt, lat, cyc, op;
      bit prev_done, op_w, to, ended, done;
      logic [NR-1:0] pend, eg, efin;
      logic [AW-1:0] ea, exa;
      logic [DW-1:0] ed, exd, erd;
      phase = P_IDLE; prev_phase = P_IDLE; prev_done = 0; g = 0; bcnt = 0; lat = 0;
      cyc = 0; ended = 0; op_w = 0; ea = '0; ed = '0;
      for (int i = 0; i < NR; i++) begin rem[i] = mask[i] ? ntx : 0; drop[i] = 0; end
      while (!ended && cyc < 3000) begin
         tick();
         pend = rd | wr;
         if (prev_phase == P_BUSY) begin
            phase = prev_done ? P_REL : P_BUSY;
            bcnt++;
         end else if (prev_phase == P_REL) begin
            phase = P_IDLE;
         end else if (pend != '0) begin
            for (int k = 1; k <= NR; k++) begin
               if (pend[(m_rr + k) % NR]) begin g = (m_rr + k) % NR; break; end
            end
            phase = P_BUSY; m_rr = g; bcnt = 1;
            op_w = wr[g]; ea = a[g]; ed = d[g];
            lat = (lat_mode == 0) ? $urandom_range(7, 1) : (lat_mode == 1) ? 0 : TO;
            gq.push_back(g);
         end else begin
            phase = P_IDLE;
         end
         for (int i = 0; i < NR; i++) begin
            if (drop[i]) begin
               rd[i] = 1'b0; wr[i] = 1'b0; drop[i] = 0;
            end else if (rem[i] > 0 && !(rd[i] | wr[i])) begin
               op = $urandom_range(2);
               rd[i] = (op != 1); wr[i] = (op != 0);
               a[i] = AW'($urandom); d[i] = $urandom;
            end else if (scramble && phase == P_BUSY && i == g) begin
               a[i] = AW'($urandom); d[i] = $urandom;
            end
         end
         rdat = $urandom;
         fin  = 1'b0;
         if (phase == P_BUSY) fin = (lat != 0 && bcnt == lat);
         else if (idle_fin) fin = 1'($urandom_range(1));
         @(negedge clk);
         eg   = (phase == P_BUSY) ? (NR'(1) << g) : '0;
         to   = (phase == P_BUSY) && (bcnt == TO) && !fin;
         efin = ((phase == P_BUSY) && (fin || to)) ? eg : '0;
         erd  = ((phase == P_BUSY) && fin) ? rdat : '0;
         exa  = (phase == P_BUSY) ? ea : '0;
         exd  = (phase == P_BUSY && op_w) ? ed : '0;
         checks++; if (bus.grant !== eg) begin failures++;
            $display("FAIL traffic_grant cyc=%0d got=%b want=%b", cyc, bus.grant, eg); end
         checks++; if (bus.sdram_read !== (phase == P_BUSY && !op_w)) begin failures++;
            $display("FAIL traffic_read cyc=%0d got=%b want=%b", cyc, bus.sdram_read, phase == P_BUSY && !op_w); end
         checks++; if (bus.sdram_write !== (phase == P_BUSY && op_w)) begin failures++;
            $display("FAIL traffic_write cyc=%0d got=%b want=%b", cyc, bus.sdram_write, phase == P_BUSY && op_w); end
         checks++; if (bus.sdram_addr !== exa) begin failures++;
            $display("FAIL traffic_addr cyc=%0d got=%h want=%h", cyc, bus.sdram_addr, exa); end
         checks++; if (bus.sdram_writedata !== exd) begin failures++;
            $display("FAIL traffic_wdata cyc=%0d got=%h want=%h", cyc, bus.sdram_writedata, exd); end
         checks++; if (bus.req_finished !== efin) begin failures++;
            $display("FAIL traffic_finished cyc=%0d got=%b want=%b", cyc, bus.req_finished, efin); end
         checks++; if (bus.req_readdata !== erd) begin failures++;
            $display("FAIL traffic_readdata cyc=%0d got=%h want=%h", cyc, bus.req_readdata, erd); end
         checks++; if (bus.timeout_err !== m_terr) begin failures++;
            $display("FAIL traffic_terr cyc=%0d got=%b want=%b", cyc, bus.timeout_err, m_terr); end
         checks++; if (bus.timeout_id !== IW'(m_tid)) begin failures++;
            $display("FAIL traffic_tid cyc=%0d got=%0d want=%0d", cyc, bus.timeout_id, m_tid); end
         done = (efin != '0);
         if (to) begin m_terr = 1'b1; m_tid = g; end
         if (done) begin rem[g]--; drop[g] = 1; end
         prev_phase = phase; prev_done = done; cyc++;
         ended = (phase == P_IDLE) && ((rd | wr) == '0);
         for (int i = 0; i < NR; i++) if (rem[i] > 0) ended = 0;
      end
      checks++; if (!ended) begin failures++;
         $display("FAIL traffic_bound got=%0d cycles want=drain", cyc); end
   endtask

   task automatic test_reset();
      rst = 1'b1; rd = '1; wr = '1; fin = 1'b1; rdat = '1;
      for (int i = 0; i < NR; i++) begin a[i] = '1; d[i] = '1; end
      repeat (3) tick();
      @(negedge clk);
      checks++; if (bus.grant !== '0 || bus.sdram_read !== 1'b0 || bus.sdram_write !== 1'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b/%b/%b want=0", bus.grant, bus.sdram_read, bus.sdram_write); end
      checks++; if (bus.sdram_addr !== '0 || bus.sdram_writedata !== '0) begin
         failures++; $display("FAIL reset_bus got=%h/%h want=0", bus.sdram_addr, bus.sdram_writedata); end
      checks++; if (bus.req_finished !== '0 || bus.req_readdata !== '0) begin
         failures++; $display("FAIL reset_resp got=%b/%h want=0", bus.req_finished, bus.req_readdata); end
      checks++; if (bus.timeout_err !== 1'b0 || bus.timeout_id !== '0) begin
         failures++; $display("FAIL reset_wdog got=%b/%0d want=0", bus.timeout_err, bus.timeout_id); end
      do_reset();
   endtask

   task automatic test_single_read();
      logic [NR-1:0] efin;
      logic [DW-1:0] erd;
      do_reset();
      rd[2] = 1'b1; a[2] = 23'h001234;
      @(negedge clk);
      checks++; if (bus.grant !== '0 || bus.sdram_read !== 1'b0) begin failures++;
         $display("FAIL single_idle got=%b/%b want=0", bus.grant, bus.sdram_read); end
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 5) rd[2] = 1'b0;
         fin  = (c == 4);
         rdat = (c == 4) ? 32'hDEADBEEF : $urandom;
         @(negedge clk);
         efin = (c == 4) ? 5'b00100 : 5'b0;
         erd  = (c == 4) ? 32'hDEADBEEF : 32'h0;
         if (c <= 4) begin
            checks++; if (bus.grant !== 5'b00100 || bus.sdram_read !== 1'b1 || bus.sdram_write !== 1'b0) begin
               failures++; $display("FAIL single_busy c=%0d got=%b/%b/%b want=00100/1/0", c, bus.grant, bus.sdram_read, bus.sdram_write); end
            checks++; if (bus.sdram_addr !== 23'h001234) begin failures++;
               $display("FAIL single_addr c=%0d got=%h want=001234", c, bus.sdram_addr); end
         end else begin
            checks++; if (bus.grant !== '0 || bus.sdram_read !== 1'b0) begin failures++;
               $display("FAIL single_release c=%0d got=%b/%b want=0", c, bus.grant, bus.sdram_read); end
         end
         checks++; if (bus.req_finished !== efin || bus.req_readdata !== erd) begin failures++;
            $display("FAIL single_finish c=%0d got=%b/%h want=%b/%h", c, bus.req_finished, bus.req_readdata, efin, erd); end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      test_traffic(5'b01011, 1, 0, 0, 0);
      checks++; if (gq.size() != 3 || gq[0] != 0 || gq[1] != 1 || gq[2] != 3) begin failures++;
         $display("FAIL simul_order got=%p want=0,1,3", gq); end
   endtask

   task automatic test_fairness();
      do_reset();
      test_traffic(5'b10010, 4, 0, 0, 1);
      checks++; if (gq.size() != 8) begin failures++;
         $display("FAIL fair_count got=%0d want=8", gq.size()); end
      for (int k = 0; k < gq.size(); k++) begin
         checks++; if (gq[k] != ((k % 2 == 0) ? 1 : 4)) begin failures++;
            $display("FAIL fair_order k=%0d got=%0d want=%0d", k, gq[k], (k % 2 == 0) ? 1 : 4); end
      end
   endtask

   task automatic test_op_latch();
      logic [AW-1:0] ga;
      do_reset();
      ga = AW'($urandom);
      rd[0] = 1'b1; wr[0] = 1'b1; a[0] = ga; d[0] = 32'hCAFEF00D;
      for (int c = 1; c <= 3; c++) begin
         tick();
         a[0] = AW'($urandom); d[0] = $urandom;
         fin = (c == 3); rdat = $urandom;
         @(negedge clk);
         checks++; if (bus.sdram_write !== 1'b1 || bus.sdram_read !== 1'b0) begin failures++;
            $display("FAIL latch_op c=%0d got=w%b/r%b want=w1/r0", c, bus.sdram_write, bus.sdram_read); end
         checks++; if (bus.sdram_addr !== ga || bus.sdram_writedata !== 32'hCAFEF00D) begin failures++;
            $display("FAIL latch_data c=%0d got=%h/%h want=%h/cafef00d", c, bus.sdram_addr, bus.sdram_writedata, ga); end
      end
      checks++; if (bus.req_finished !== 5'b00001) begin failures++;
         $display("FAIL latch_finish got=%b want=00001", bus.req_finished); end
      tick();
      rd = '0; wr = '0; fin = 1'b0;
      @(negedge clk);
      m_rr = 0;
      gq.delete();
      test_traffic(5'b11111, 4, 0, 1, 1);
      checks++; if (gq.size() != 20) begin failures++;
         $display("FAIL latch_grants got=%0d want=20", gq.size()); end
   endtask

   task automatic test_watchdog();
      do_reset();
      test_traffic(5'b00001, 1, 2, 0, 0);
      checks++; if (bus.timeout_err !== 1'b0) begin failures++;
         $display("FAIL wdog_coincide got=%b want=0", bus.timeout_err); end
      test_traffic(5'b01000, 1, 1, 0, 1);
      checks++; if (bus.timeout_err !== 1'b1 || bus.timeout_id !== 3'd3) begin failures++;
         $display("FAIL wdog_abort got=%b/%0d want=1/3", bus.timeout_err, bus.timeout_id); end
      test_traffic(5'b00110, 3, 0, 0, 1);
      checks++; if (bus.timeout_err !== 1'b1 || bus.timeout_id !== 3'd3) begin failures++;
         $display("FAIL wdog_sticky got=%b/%0d want=1/3", bus.timeout_err, bus.timeout_id); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      rd[2] = 1'b1; a[2] = AW'($urandom);
      tick();
      @(negedge clk);
      checks++; if (bus.grant !== 5'b00100) begin failures++;
         $display("FAIL rstmid_busy got=%b want=00100", bus.grant); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; rd[0] = 1'b1; a[0] = AW'($urandom); fin = 1'b1; rdat = $urandom;
      @(negedge clk);
      checks++; if (bus.grant !== '0 || bus.sdram_read !== 1'b0 || bus.sdram_write !== 1'b0 || bus.sdram_addr !== '0) begin
         failures++; $display("FAIL rstmid_zero got=%b/%b/%b/%h want=0", bus.grant, bus.sdram_read, bus.sdram_write, bus.sdram_addr); end
      checks++; if (bus.req_finished !== '0 || bus.req_readdata !== '0) begin failures++;
         $display("FAIL rstmid_nofinish got=%b/%h want=0", bus.req_finished, bus.req_readdata); end
      tick();
      fin = 1'b0;
      @(negedge clk);
      checks++; if (bus.grant !== 5'b00001 || bus.sdram_read !== 1'b1 || bus.sdram_addr !== a[0]) begin failures++;
         $display("FAIL rstmid_regrant got=%b/%b/%h want=00001/1/%h", bus.grant, bus.sdram_read, bus.sdram_addr, a[0]); end
      rd = '0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_fairness();
      test_op_latch();
      test_watchdog();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
